// File: rtl/store_buffer.sv
// Posted-write buffer between the memory stage and data_memory: queues CPU
// stores, drains one per non-load cycle and forwards the youngest match to loads.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] cpu_a,
  input  logic          cpu_we,
  input  logic          cpu_re,
  input  logic [DW-1:0] cpu_wd,
  output logic [DW-1:0] cpu_rd,
  output logic          cpu_stall,
  output logic [AW-1:0] mem_a,
  output logic          mem_we,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic          buf_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-3:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic full, empty, load_cyc, accept, drain;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign load_cyc = cpu_re & ~cpu_we;
  assign accept   = cpu_we & ~full;
  assign drain    = ~empty & ~load_cyc;

  // Pointer and occupancy next state; both pointers move on accept+drain.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) wr_ptr_d = wr_ptr_q + PW'(1);
    if (drain)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (accept && !drain)      count_d = count_q + CW'(1);
    else if (!accept && drain) count_d = count_q - CW'(1);
  end

  // Walk valid entries oldest to youngest so the last match (youngest) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count_q) && (addr_q[rd_ptr_q + PW'(k)] == cpu_a[AW-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[rd_ptr_q + PW'(k)];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: entry storage is not reset; validity comes from count/rd_ptr, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q[wr_ptr_q] <= cpu_a[AW-1:2];
      data_q[wr_ptr_q] <= cpu_wd;
    end
  end

  assign cpu_stall = cpu_we & full;
  assign mem_we    = drain;
  assign mem_a     = drain ? {addr_q[rd_ptr_q], 2'b00} : cpu_a;
  assign mem_wd    = drain ? data_q[rd_ptr_q] : cpu_wd;
  assign cpu_rd    = (load_cyc && fwd_hit) ? fwd_data : mem_rd;
  assign buf_empty = empty;

endmodule
